// File: rtl/main_control_pkg.sv
// Shared definitions for the multicycle main control FSM and the ALU control stage:
// state encodings, opcodes, ALUOp classes, datapath select codes and the control bundle.
package main_control_pkg;

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    RWB    = 4'd7,
    BRANCH = 4'd8,
    JUMP   = 4'd9,
    ADDIEX = 4'd10,
    ADDIWB = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REGB  = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic [1:0] aluOp;
    logic       aluSrcA;
    logic [1:0] aluSrcB;
    logic [1:0] pcSource;
    logic       pcWrite;
    logic       pcWriteCond;
    logic       iorD;
    logic       memRead;
    logic       memWrite;
    logic       irWrite;
    logic       memtoReg;
    logic       regDst;
    logic       regWrite;
  } ctrl_t;

  // addi legality depends on the build-time enable; everything else is fixed
  function automatic logic isLegalOp(input logic [5:0] op, input logic enAddi);
    logic legal;
    legal = 1'b0;
    case (op)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J: legal = 1'b1;
      OP_ADDI:                              legal = enAddi;
      default:                              legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/main_control_decode.sv
// Combinational state-to-control decoder for the multicycle main control FSM.
// Unlisted controls stay 0, and unused encodings decode to all-zero.
module main_control_decode
  import main_control_pkg::*;
(
  input  state_t i_state,
  output ctrl_t  o_ctrl
);

  always_comb begin
    o_ctrl = '0;
    case (i_state)
      FETCH: begin
        o_ctrl.memRead  = 1'b1;
        o_ctrl.irWrite  = 1'b1;
        o_ctrl.iorD     = 1'b0;
        o_ctrl.aluSrcA  = 1'b0;
        o_ctrl.aluSrcB  = SRCB_FOUR;
        o_ctrl.aluOp    = ALUOP_ADD;
        o_ctrl.pcSource = PCSRC_ALU;
        o_ctrl.pcWrite  = 1'b1;
      end
      DECODE: begin
        o_ctrl.aluSrcA = 1'b0;
        o_ctrl.aluSrcB = SRCB_IMMSH;
        o_ctrl.aluOp   = ALUOP_ADD;
      end
      MEMADR: begin
        o_ctrl.aluSrcA = 1'b1;
        o_ctrl.aluSrcB = SRCB_IMM;
        o_ctrl.aluOp   = ALUOP_ADD;
      end
      MEMRD: begin
        o_ctrl.memRead = 1'b1;
        o_ctrl.iorD    = 1'b1;
      end
      MEMWB: begin
        o_ctrl.regWrite = 1'b1;
        o_ctrl.memtoReg = 1'b1;
        o_ctrl.regDst   = 1'b0;
      end
      MEMWR: begin
        o_ctrl.memWrite = 1'b1;
        o_ctrl.iorD     = 1'b1;
      end
      EXEC: begin
        o_ctrl.aluSrcA = 1'b1;
        o_ctrl.aluSrcB = SRCB_REGB;
        o_ctrl.aluOp   = ALUOP_FUNCT;
      end
      RWB: begin
        o_ctrl.regWrite = 1'b1;
        o_ctrl.regDst   = 1'b1;
        o_ctrl.memtoReg = 1'b0;
      end
      BRANCH: begin
        o_ctrl.aluSrcA     = 1'b1;
        o_ctrl.aluSrcB     = SRCB_REGB;
        o_ctrl.aluOp       = ALUOP_SUB;
        o_ctrl.pcWriteCond = 1'b1;
        o_ctrl.pcSource    = PCSRC_ALUOUT;
      end
      JUMP: begin
        o_ctrl.pcWrite  = 1'b1;
        o_ctrl.pcSource = PCSRC_JUMP;
      end
      ADDIEX: begin
        o_ctrl.aluSrcA = 1'b1;
        o_ctrl.aluSrcB = SRCB_IMM;
        o_ctrl.aluOp   = ALUOP_ADD;
      end
      ADDIWB: begin
        o_ctrl.regWrite = 1'b1;
        o_ctrl.regDst   = 1'b0;
        o_ctrl.memtoReg = 1'b0;
      end
      default: o_ctrl = '0;
    endcase
  end

endmodule

// File: rtl/main_control_fsm.sv
// Multicycle MIPS main control FSM: state register, opcode latch and next-state logic;
// control outputs come from the state via main_control_decode.
module main_control_fsm
  import main_control_pkg::*;
#(
  parameter bit EN_ADDI = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Opcode,
  output logic [1:0] ALUOp,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSource,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       IllegalOp
);

  state_t     r_state;
  state_t     w_nextState;
  logic [5:0] r_opcode;
  ctrl_t      w_ctrl;
  ctrl_t      w_ctrlGated;
  logic       w_illegal;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= FETCH;
      r_opcode <= '0;
    end else begin
      r_state <= w_nextState;
      if (r_state == DECODE) begin
        r_opcode <= Opcode;
      end
    end
  end

  // Only DECODE looks at the live Opcode; MEMADR uses the copy latched at that edge
  always_comb begin
    w_nextState = FETCH;
    case (r_state)
      FETCH: w_nextState = DECODE;
      DECODE: begin
        case (Opcode)
          OP_LW, OP_SW: w_nextState = MEMADR;
          OP_RTYPE:     w_nextState = EXEC;
          OP_BEQ:       w_nextState = BRANCH;
          OP_J:         w_nextState = JUMP;
          OP_ADDI:      w_nextState = EN_ADDI ? ADDIEX : FETCH;
          default:      w_nextState = FETCH;
        endcase
      end
      MEMADR:  w_nextState = (r_opcode == OP_SW) ? MEMWR : MEMRD;
      MEMRD:   w_nextState = MEMWB;
      EXEC:    w_nextState = RWB;
      ADDIEX:  w_nextState = ADDIWB;
      default: w_nextState = FETCH;
    endcase
  end

  assign w_illegal = (r_state == DECODE) && !isLegalOp(Opcode, EN_ADDI);

  main_control_decode u_decode (
    .i_state (r_state),
    .o_ctrl  (w_ctrl)
  );

  // Reset forces FETCH, but FETCH strobes must not reach the datapath until release
  assign w_ctrlGated = reset ? '0 : w_ctrl;

  assign ALUOp       = w_ctrlGated.aluOp;
  assign ALUSrcA     = w_ctrlGated.aluSrcA;
  assign ALUSrcB     = w_ctrlGated.aluSrcB;
  assign PCSource    = w_ctrlGated.pcSource;
  assign PCWrite     = w_ctrlGated.pcWrite;
  assign PCWriteCond = w_ctrlGated.pcWriteCond;
  assign IorD        = w_ctrlGated.iorD;
  assign MemRead     = w_ctrlGated.memRead;
  assign MemWrite    = w_ctrlGated.memWrite;
  assign IRWrite     = w_ctrlGated.irWrite;
  assign MemtoReg    = w_ctrlGated.memtoReg;
  assign RegDst      = w_ctrlGated.regDst;
  assign RegWrite    = w_ctrlGated.regWrite;
  assign IllegalOp   = w_illegal && !reset;

endmodule

// File: tb/tb_main_control_fsm.sv
// Self-checking bench for main_control_fsm: per-cycle expected control vectors are
// queued per instruction and compared against the DUT mid-cycle.
module tb_main_control_fsm;

  logic       clk;
  logic       reset;
  logic [5:0] Opcode;

  logic [1:0] ALUOp1, ALUSrcB1, PCSource1;
  logic       ALUSrcA1, PCWrite1, PCWriteCond1, IorD1, MemRead1, MemWrite1;
  logic       IRWrite1, MemtoReg1, RegDst1, RegWrite1, IllegalOp1;
  logic [1:0] ALUOp2, ALUSrcB2, PCSource2;
  logic       ALUSrcA2, PCWrite2, PCWriteCond2, IorD2, MemRead2, MemWrite2;
  logic       IRWrite2, MemtoReg2, RegDst2, RegWrite2, IllegalOp2;

  logic [16:0] obs1, obs2;

  main_control_fsm #(.EN_ADDI(1'b1)) dut (
    .clk(clk), .reset(reset), .Opcode(Opcode),
    .ALUOp(ALUOp1), .ALUSrcA(ALUSrcA1), .ALUSrcB(ALUSrcB1), .PCSource(PCSource1),
    .PCWrite(PCWrite1), .PCWriteCond(PCWriteCond1), .IorD(IorD1), .MemRead(MemRead1),
    .MemWrite(MemWrite1), .IRWrite(IRWrite1), .MemtoReg(MemtoReg1), .RegDst(RegDst1),
    .RegWrite(RegWrite1), .IllegalOp(IllegalOp1)
  );

  main_control_fsm #(.EN_ADDI(1'b0)) dutNoAddi (
    .clk(clk), .reset(reset), .Opcode(Opcode),
    .ALUOp(ALUOp2), .ALUSrcA(ALUSrcA2), .ALUSrcB(ALUSrcB2), .PCSource(PCSource2),
    .PCWrite(PCWrite2), .PCWriteCond(PCWriteCond2), .IorD(IorD2), .MemRead(MemRead2),
    .MemWrite(MemWrite2), .IRWrite(IRWrite2), .MemtoReg(MemtoReg2), .RegDst(RegDst2),
    .RegWrite(RegWrite2), .IllegalOp(IllegalOp2)
  );

  assign obs1 = {ALUOp1, ALUSrcA1, ALUSrcB1, PCSource1, PCWrite1, PCWriteCond1, IorD1,
                 MemRead1, MemWrite1, IRWrite1, MemtoReg1, RegDst1, RegWrite1, IllegalOp1};
  assign obs2 = {ALUOp2, ALUSrcA2, ALUSrcB2, PCSource2, PCWrite2, PCWriteCond2, IorD2,
                 MemRead2, MemWrite2, IRWrite2, MemtoReg2, RegDst2, RegWrite2, IllegalOp2};

  // aluop_srca_srcb_pcsrc_pcw_pcwc_iord_mrd_mwr_irw_m2r_rdst_rw_ill
  localparam logic [16:0] E_ZERO   = 17'b00_0_00_00_0_0_0_0_0_0_0_0_0_0;
  localparam logic [16:0] E_FETCH  = 17'b00_0_01_00_1_0_0_1_0_1_0_0_0_0;
  localparam logic [16:0] E_DECODE = 17'b00_0_11_00_0_0_0_0_0_0_0_0_0_0;
  localparam logic [16:0] E_DECILL = 17'b00_0_11_00_0_0_0_0_0_0_0_0_0_1;
  localparam logic [16:0] E_MEMADR = 17'b00_1_10_00_0_0_0_0_0_0_0_0_0_0;
  localparam logic [16:0] E_MEMRD  = 17'b00_0_00_00_0_0_1_1_0_0_0_0_0_0;
  localparam logic [16:0] E_MEMWB  = 17'b00_0_00_00_0_0_0_0_0_0_1_0_1_0;
  localparam logic [16:0] E_MEMWR  = 17'b00_0_00_00_0_0_1_0_1_0_0_0_0_0;
  localparam logic [16:0] E_EXEC   = 17'b10_1_00_00_0_0_0_0_0_0_0_0_0_0;
  localparam logic [16:0] E_RWB    = 17'b00_0_00_00_0_0_0_0_0_0_0_1_1_0;
  localparam logic [16:0] E_BRANCH = 17'b01_1_00_01_0_1_0_0_0_0_0_0_0_0;
  localparam logic [16:0] E_JUMP   = 17'b00_0_00_10_1_0_0_0_0_0_0_0_0_0;
  localparam logic [16:0] E_ADDIEX = 17'b00_1_10_00_0_0_0_0_0_0_0_0_0_0;
  localparam logic [16:0] E_ADDIWB = 17'b00_0_00_00_0_0_0_0_0_0_0_0_1_0;

  int errors = 0;
  int checks = 0;
  logic [16:0] expQ[$];
  string       nameQ[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  // Expected per-cycle vectors for one instruction starting in FETCH (EN_ADDI=1 DUT)
  task automatic applyStimulus(input logic [5:0] op);
    Opcode = op;
    expQ.push_back(E_FETCH); nameQ.push_back("fetch");
    case (op)
      6'b100011: begin
        expQ.push_back(E_DECODE); nameQ.push_back("decode");
        expQ.push_back(E_MEMADR); nameQ.push_back("memadr");
        expQ.push_back(E_MEMRD);  nameQ.push_back("memrd");
        expQ.push_back(E_MEMWB);  nameQ.push_back("memwb");
      end
      6'b101011: begin
        expQ.push_back(E_DECODE); nameQ.push_back("decode");
        expQ.push_back(E_MEMADR); nameQ.push_back("memadr");
        expQ.push_back(E_MEMWR);  nameQ.push_back("memwr");
      end
      6'b000000: begin
        expQ.push_back(E_DECODE); nameQ.push_back("decode");
        expQ.push_back(E_EXEC);   nameQ.push_back("exec");
        expQ.push_back(E_RWB);    nameQ.push_back("rwb");
      end
      6'b000100: begin
        expQ.push_back(E_DECODE); nameQ.push_back("decode");
        expQ.push_back(E_BRANCH); nameQ.push_back("branch");
      end
      6'b000010: begin
        expQ.push_back(E_DECODE); nameQ.push_back("decode");
        expQ.push_back(E_JUMP);   nameQ.push_back("jump");
      end
      6'b001000: begin
        expQ.push_back(E_DECODE); nameQ.push_back("decode");
        expQ.push_back(E_ADDIEX); nameQ.push_back("addiex");
        expQ.push_back(E_ADDIWB); nameQ.push_back("addiwb");
      end
      default: begin
        expQ.push_back(E_DECILL); nameQ.push_back("decode_illegal");
      end
    endcase
  endtask

  task automatic applyReset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    Opcode = 6'b000000;
    #1;
    checks++;
    if (obs1 !== E_ZERO) begin errors++; $display("[TB] FAIL reset_outputs: got %b expected %b", obs1, E_ZERO); end
    checks++;
    if (obs2 !== E_ZERO) begin errors++; $display("[TB] FAIL reset_outputs_noaddi: got %b expected %b", obs2, E_ZERO); end
    @(posedge clk); #1;
    checks++;
    if (obs1 !== E_ZERO) begin errors++; $display("[TB] FAIL reset_held_edge: got %b expected %b", obs1, E_ZERO); end
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (obs1 !== E_FETCH) begin errors++; $display("[TB] FAIL reset_release_fetch: got %b expected %b", obs1, E_FETCH); end
    checks++;
    if (obs2 !== E_FETCH) begin errors++; $display("[TB] FAIL reset_release_fetch_noaddi: got %b expected %b", obs2, E_FETCH); end
  endtask

  task automatic test_sequence(input logic [5:0] op, input string label);
    logic [16:0] exp;
    string nm;
    applyStimulus(op);
    while (expQ.size() != 0) begin
      exp = expQ.pop_front();
      nm  = nameQ.pop_front();
      checks++;
      if (obs1 !== exp) begin errors++; $display("[TB] FAIL %s_%s: got %b expected %b", label, nm, obs1, exp); end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    test_sequence(6'b000100, "b2b_beq");
    test_sequence(6'b000010, "b2b_j");
  endtask

  task automatic test_illegal();
    test_sequence(6'b111111, "illegal");
    test_sequence(6'b000010, "after_illegal_j");
  endtask

  task automatic test_opcode_latch();
    logic [16:0] exp;
    string nm;
    applyStimulus(6'b101011);
    for (int i = 0; i < 4; i++) begin
      if (i == 2) Opcode = 6'b100011;
      exp = expQ.pop_front();
      nm  = nameQ.pop_front();
      checks++;
      if (obs1 !== exp) begin errors++; $display("[TB] FAIL latch_sw_%s: got %b expected %b", nm, obs1, exp); end
      @(negedge clk);
    end
    applyStimulus(6'b100011);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) Opcode = 6'b101011;
      exp = expQ.pop_front();
      nm  = nameQ.pop_front();
      checks++;
      if (obs1 !== exp) begin errors++; $display("[TB] FAIL latch_lw_%s: got %b expected %b", nm, obs1, exp); end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid_memwr();
    logic [16:0] exp;
    string nm;
    applyStimulus(6'b101011);
    for (int i = 0; i < 4; i++) begin
      exp = expQ.pop_front();
      nm  = nameQ.pop_front();
      checks++;
      if (obs1 !== exp) begin errors++; $display("[TB] FAIL abort_%s: got %b expected %b", nm, obs1, exp); end
      if (i < 3) @(negedge clk);
    end
    #1 reset = 1'b1;
    #1;
    checks++;
    if (MemWrite1 !== 1'b0) begin errors++; $display("[TB] FAIL abort_memwrite_drop: got %b expected 0", MemWrite1); end
    checks++;
    if (obs1 !== E_ZERO) begin errors++; $display("[TB] FAIL abort_all_zero: got %b expected %b", obs1, E_ZERO); end
    #1 reset = 1'b0;
    #1;
    checks++;
    if (obs1 !== E_FETCH) begin errors++; $display("[TB] FAIL abort_release_fetch: got %b expected %b", obs1, E_FETCH); end
    @(negedge clk);
    checks++;
    if (obs1 !== E_DECODE) begin errors++; $display("[TB] FAIL abort_then_decode: got %b expected %b", obs1, E_DECODE); end
    applyReset();
  endtask

  task automatic test_addi_disabled();
    logic [16:0] seq[3];
    seq[0] = E_FETCH;
    seq[1] = E_DECILL;
    seq[2] = E_FETCH;
    applyReset();
    Opcode = 6'b001000;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (obs2 !== seq[i]) begin errors++; $display("[TB] FAIL addi_disabled_cycle%0d: got %b expected %b", i + 1, obs2, seq[i]); end
      if (i == 1) begin
        checks++;
        if (obs1 !== E_DECODE) begin errors++; $display("[TB] FAIL addi_enabled_decode: got %b expected %b", obs1, E_DECODE); end
      end
      @(negedge clk);
    end
  endtask

  initial begin
    reset  = 1'b1;
    Opcode = 6'b000000;
    test_reset();
    test_sequence(6'b100011, "lw");
    test_sequence(6'b101011, "sw");
    test_sequence(6'b000000, "rtype");
    test_back_to_back();
    test_illegal();
    test_opcode_latch();
    test_sequence(6'b001000, "addi");
    test_reset_mid_memwr();
    test_sequence(6'b000000, "rtype_after_abort");
    test_addi_disabled();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
